// File: rtl/aes_uart_pkg.sv
// rtl/aes_uart_pkg.sv - shared command codes, FSM encoding and block width for the UART-to-AES framer
package aes_uart_pkg;

  localparam int BLOCK_W = 128;

  localparam logic [7:0] CMD_KEY = 8'h4B;
  localparam logic [7:0] CMD_ENC = 8'h45;
  localparam logic [7:0] CMD_DEC = 8'h44;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    WAIT_KEY = 2'd2
  } state_t;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_KEY) || (b == CMD_ENC) || (b == CMD_DEC);
  endfunction

endpackage

// File: rtl/aes_byte_shifter.sv
// rtl/aes_byte_shifter.sv - 16-byte MSB-first shift register with wrapping byte counter
module aes_byte_shifter
  import aes_uart_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift_en,
  input  logic [7:0]         data,
  output logic [BLOCK_W-1:0] block,
  output logic               last
);

  logic [3:0] count;

  // last is combinational so the top can capture the completed block on the same edge
  assign last = shift_en && (count == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) begin
      block <= '0;
      count <= 4'd0;
    end else if (clear) begin
      count <= 4'd0;
    end else if (shift_en) begin
      block <= {block[BLOCK_W-9:0], data};
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/aes_frame_assembler.sv
// rtl/aes_frame_assembler.sv - assembles UART command frames into AES key/encrypt/decrypt requests
// Optional inter-byte timeout enabled by defining AES_FRAME_TIMEOUT_EN.
module aes_frame_assembler
  import aes_uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 17360
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic               key_is_valid,
  input  logic               done_key_expansion,
  output logic               load_new_key,
  output logic [BLOCK_W-1:0] cipher_key,
  output logic               enc_in_valid,
  output logic [BLOCK_W-1:0] plain_text,
  output logic               dec_in_valid,
  output logic [BLOCK_W-1:0] cipher_text_in,
  output logic               busy,
  output logic               err_bad_cmd,
  output logic               err_no_key,
  output logic               err_overrun,
  output logic               err_timeout
);

  state_t             state;
  logic [7:0]         cmd;
  logic               shift_en;
  logic               clear;
  logic               last;
  logic               timeout_hit;
  logic [BLOCK_W-1:0] block;
  logic [BLOCK_W-1:0] next_block;

  assign shift_en   = (state == COLLECT) && rx_valid;
  assign clear      = (state == IDLE) && rx_valid && is_cmd(rx_data);
  assign next_block = {block[BLOCK_W-9:0], rx_data};
  assign busy       = (state != IDLE);

  aes_byte_shifter u_shifter (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .shift_en (shift_en),
    .data     (rx_data),
    .block    (block),
    .last     (last)
  );

`ifdef AES_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;

  assign timeout_hit = (state == COLLECT) && !rx_valid && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state != COLLECT || rx_valid) idle_cnt <= '0;
    else                                     idle_cnt <= idle_cnt + 1'b1;
    err_timeout <= !rst && timeout_hit;
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cmd            <= 8'h00;
      load_new_key   <= 1'b0;
      enc_in_valid   <= 1'b0;
      dec_in_valid   <= 1'b0;
      err_bad_cmd    <= 1'b0;
      err_no_key     <= 1'b0;
      err_overrun    <= 1'b0;
      cipher_key     <= '0;
      plain_text     <= '0;
      cipher_text_in <= '0;
    end else begin
      load_new_key <= 1'b0;
      enc_in_valid <= 1'b0;
      dec_in_valid <= 1'b0;
      err_bad_cmd  <= 1'b0;
      err_no_key   <= 1'b0;
      err_overrun  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_valid) begin
            if (is_cmd(rx_data)) begin
              cmd   <= rx_data;
              state <= COLLECT;
            end else begin
              err_bad_cmd <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (timeout_hit) begin
            state <= IDLE;
          end else if (last) begin
            // outputs load with the strobe so both appear together one cycle after the last byte
            if (cmd == CMD_KEY) begin
              cipher_key   <= next_block;
              load_new_key <= 1'b1;
              state        <= WAIT_KEY;
            end else begin
              state <= IDLE;
              if (!key_is_valid) begin
                err_no_key <= 1'b1;
              end else if (cmd == CMD_ENC) begin
                plain_text   <= next_block;
                enc_in_valid <= 1'b1;
              end else begin
                cipher_text_in <= next_block;
                dec_in_valid   <= 1'b1;
              end
            end
          end
        end
        WAIT_KEY: begin
          if (rx_valid)           err_overrun <= 1'b1;
          if (done_key_expansion) state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_frame_assembler.md
AES_FRAME_ASSEMBLER -- requirements
Module: aes_frame_assembler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 17360, meaning the inter-byte idle limit in clk cycles (two UART byte times at 115200 baud on 100 MHz).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port rx_valid, input, 1: one-cycle strobe, rx_data holds a received UART byte.
REQ-005 SHALL have port rx_data, input, 8: the received byte.
REQ-006 SHALL have port key_is_valid, input, 1: AES core holds an expanded key.
REQ-007 SHALL have port done_key_expansion, input, 1: AES core has finished key expansion.
REQ-008 SHALL have port load_new_key, output, 1: one-cycle key load strobe.
REQ-009 SHALL have port cipher_key, output, 128: assembled key.
REQ-010 SHALL have port enc_in_valid, output, 1: one-cycle encrypt strobe.
REQ-011 SHALL have port plain_text, output, 128: assembled plaintext.
REQ-012 SHALL have port dec_in_valid, output, 1: one-cycle decrypt strobe.
REQ-013 SHALL have port cipher_text_in, output, 128: assembled ciphertext.
REQ-014 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-015 SHALL have ports err_bad_cmd, err_no_key, err_overrun, err_timeout, output, 1 each: one-cycle error pulses.

Function
REQ-016 Frame SHALL be one command byte then 16 data bytes; commands: 8'h4B key, 8'h45 encrypt, 8'h44 decrypt.
REQ-017 FSM states SHALL be IDLE, COLLECT, WAIT_KEY.
REQ-018 IDLE + rx_valid with a valid command SHALL latch the command, clear the 4-bit byte counter and go to COLLECT.
REQ-019 IDLE + rx_valid with any other byte SHALL pulse err_bad_cmd next cycle and remain in IDLE.
REQ-020 COLLECT SHALL shift each byte in MSB-first: block <= {block[119:0], rx_data}; first data byte ends in bits 127:120.
REQ-021 On the 16th data byte (edge N), the counter SHALL wrap to 0 and exactly one strobe SHALL be high during cycle N+1, with its 128-bit output already updated and held until that output's next completed frame.
REQ-022 Key frame completion SHALL pulse load_new_key and go to WAIT_KEY; WAIT_KEY SHALL return to IDLE on the first cycle done_key_expansion is high.
REQ-023 Encrypt/decrypt completion with key_is_valid low SHALL NOT pulse the strobe, SHALL pulse err_no_key instead, and leave the data output unchanged.
REQ-024 rx_valid during WAIT_KEY SHALL drop the byte and pulse err_overrun.
REQ-025 A byte arriving in the same cycle as a completion strobe SHALL be processed as a command byte in IDLE.
REQ-026 Encrypt/decrypt completion SHALL go directly to IDLE; back-to-back frames SHALL be accepted with no gap.

Reset
REQ-027 rst SHALL force IDLE, counter 0, all strobes and error pulses 0, busy 0, cipher_key/plain_text/cipher_text_in 128'h0, discarding any partial frame.

Configuration
REQ-028 With AES_FRAME_TIMEOUT_EN defined, an idle counter SHALL clear on every byte in COLLECT; reaching TIMEOUT_CYCLES SHALL pulse err_timeout and return to IDLE, discarding the partial frame.
REQ-029 Without AES_FRAME_TIMEOUT_EN, no idle counter SHALL exist, err_timeout SHALL be tied 0, and COLLECT waits indefinitely.

Structure
REQ-030 Command byte constants, the state encoding and the 128-bit block width SHALL live in shared package aes_uart_pkg.
REQ-031 The 16-byte shift register plus counter SHALL be the sub-module aes_byte_shifter; FSM and error logic stay in the top.

Verification
REQ-032 Key: 4B,00,01..0F -> load_new_key high one cycle, cipher_key=000102030405060708090a0b0c0d0e0f, busy until done_key_expansion driven 12 cycles later.
REQ-033 Encrypt after key: 45,00,11,22..FF -> enc_in_valid one cycle, plain_text=00112233445566778899aabbccddeeff; back-to-back 45+16x01 -> second pulse with 0101...01.
REQ-034 Encrypt with key_is_valid=0 -> err_no_key one pulse, enc_in_valid never high, plain_text unchanged.
REQ-035 Byte 41 in IDLE -> err_bad_cmd one pulse, busy stays 0; byte during WAIT_KEY -> err_overrun.
REQ-036 AES_FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=50: 45 + 5 bytes then 50 idle cycles -> err_timeout, busy 0; next full frame correct.
REQ-037 rst asserted after 8 data bytes -> all outputs 0 next cycle; following full decrypt frame 44 + 16xFF -> dec_in_valid, cipher_text_in all ones.
